// File: rtl/l1_stream.sv
// ---------------------------------------------------------------------------
// l1_stream
//   Reads the 32x32 max-pooled result (1024 signed Q4.16 words) from memory in
//   raster order. Each word goes through a 4-entry FIFO to a valid/ready
//   output stream. A running sum and the running maximum (with its index) are
//   computed over the handshaken words.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      one-cycle pulse that begins a readout (honoured only in IDLE)
//   busy       high from the start-accept edge until the done edge
//   done       one-cycle pulse after the final output handshake
//   crd        registered memory read enable
//   caddr_rd   registered memory read address (bits [11:10] always 0)
//   cdata_rd   read data for the word addressed in the current crd cycle
//   csel       memory select: 3'b011 while busy, 3'b000 otherwise
//   out_valid  FIFO not empty
//   out_ready  downstream ready; a transfer occurs when valid and ready are both 1
//   out_data   FIFO head value
//   out_idx    FIFO head raster index
//   out_last   high with out_valid when out_idx is 1023
//   max_val    running signed maximum
//   max_idx    raster index of max_val
//   sum        running signed sum (30 bits, wraps)
// ---------------------------------------------------------------------------
module l1_stream (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        crd,
    output logic [11:0] caddr_rd,
    input  logic [19:0] cdata_rd,
    output logic [2:0]  csel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [19:0] out_data,
    output logic [9:0]  out_idx,
    output logic        out_last,
    output logic [19:0] max_val,
    output logic [9:0]  max_idx,
    output logic [29:0] sum
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam logic [9:0] LAST_IDX = 10'd1023;

    logic [1:0]  state;

    // Output FIFO: value and raster index of each word that has been read.
    logic [19:0] fifo_data [0:3];
    logic [9:0]  fifo_idx  [0:3];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;

    // Set by an accepted start so the first handshake loads max_val/max_idx.
    logic        first;

    logic        push;
    logic        pop;
    logic        last_read;
    logic [2:0]  occ_next;
    logic [19:0] head_data;
    logic [9:0]  head_idx;

    // A read issued in this cycle lands in the FIFO at the edge that ends it.
    assign push      = crd;
    assign pop       = out_valid && out_ready;
    assign last_read = crd && (caddr_rd[9:0] == LAST_IDX);
    assign occ_next  = count + {2'b00, push} - {2'b00, pop};

    assign head_data = fifo_data[rd_ptr];
    assign head_idx  = fifo_idx[rd_ptr];

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FIN);
    assign csel      = busy ? 3'b011 : 3'b000;

    assign out_valid = (count != 3'd0);
    // The FIFO storage is not reset, so the head is masked while the FIFO is
    // empty. This keeps the outputs at zero out of reset.
    assign out_data  = out_valid ? head_data : 20'd0;
    assign out_idx   = out_valid ? head_idx  : 10'd0;
    assign out_last  = out_valid && (head_idx == LAST_IDX);

    // NOTE: FIFO storage has no reset. Only the pointers and count need a known
    // value, and leaving the data array unreset keeps it a plain register file.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= cdata_rd;
            fifo_idx[wr_ptr]  <= caddr_rd[9:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples values from before the edge, and the order of statements
    // below does not affect the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            crd      <= 1'b0;
            caddr_rd <= 12'd0;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            first    <= 1'b0;
            sum      <= 30'd0;
            max_val  <= 20'd0;
            max_idx  <= 10'd0;
        end else if (state == S_IDLE && start) begin
            state    <= S_RUN;
            crd      <= 1'b1;
            caddr_rd <= 12'd0;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            first    <= 1'b1;
            sum      <= 30'd0;
            max_val  <= 20'd0;
            max_idx  <= 10'd0;
        end else begin
            // FIFO bookkeeping
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            count <= occ_next;

            // Statistics over the handshaken words
            if (pop) begin
                sum <= sum + {{10{out_data[19]}}, out_data};
                if (first || ($signed(out_data) > $signed(max_val))) begin
                    max_val <= out_data;
                    max_idx <= out_idx;
                end
                first <= 1'b0;
            end

            case (state)
                S_RUN: begin
                    if (last_read) begin
                        state <= S_DRAIN;
                        crd   <= 1'b0;
                    end else begin
                        // When crd is low, caddr_rd already holds the next
                        // address to issue. Another read is issued only if the
                        // FIFO holds at most 2 words after this edge, which
                        // leaves room for that read to land.
                        if (crd) caddr_rd <= caddr_rd + 12'd1;
                        crd <= (occ_next <= 3'd2);
                    end
                end
                S_DRAIN: begin
                    if (pop && out_last) state <= S_FIN;
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_stream.sv
// ---------------------------------------------------------------------------
// tb_l1_stream
//   Scoreboard bench for l1_stream. The stimulus process fills a memory image,
//   pushes the 1024 expected output words into a queue and pulses start. A
//   monitor process pops and compares on every output handshake. The monitor
//   also tracks read order, FIFO occupancy and data stability during stalls.
// ---------------------------------------------------------------------------
module tb_l1_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd;
    logic [2:0]  csel;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_data;
    logic [9:0]  out_idx;
    logic        out_last;
    logic [19:0] max_val;
    logic [9:0]  max_idx;
    logic [29:0] sum;

    always #5 clk = ~clk;

    l1_stream dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .crd       (crd),
        .caddr_rd  (caddr_rd),
        .cdata_rd  (cdata_rd),
        .csel      (csel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .max_val   (max_val),
        .max_idx   (max_idx),
        .sum       (sum)
    );

    // Memory image seen by the DUT
    logic [19:0] mem [0:1023];
    assign cdata_rd = mem[caddr_rd[9:0]];

    typedef struct {
        logic [19:0] data;
        logic [9:0]  idx;
        logic        last;
    } exp_t;

    exp_t exp_q[$];

    int n_checks  = 0;
    int n_fail    = 0;
    int done_cnt  = 0;
    int ready_mode = 0;   // 0: always ready, 1: random with 10-cycle stalls

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- out_ready driver ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 0) begin
                out_ready = 1'b1;
            end else if ($urandom_range(0, 39) == 0) begin
                out_ready = 1'b0;
                repeat (9) begin @(posedge clk); #1; end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int          occ = 0;
    int          exp_rd = 0;
    logic        stalled = 1'b0;
    logic [19:0] prev_data;
    logic [9:0]  prev_idx;
    logic        prev_last;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            occ     = 0;
            exp_rd  = 0;
            stalled = 1'b0;
        end else begin
            if (done) done_cnt++;
            // An accepted start empties the FIFO and restarts the read sequence.
            if (start && !busy) begin
                occ    = 0;
                exp_rd = 0;
            end
            if (stalled) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data",  {12'd0, out_data}, {12'd0, prev_data});
                check("stall_idx",   {22'd0, out_idx},  {22'd0, prev_idx});
                check("stall_last",  {31'd0, out_last}, {31'd0, prev_last});
            end
            check("valid_vs_occ", {31'd0, out_valid}, {31'd0, (occ != 0)});
            check("occ_max", {31'd0, (occ <= 4)}, 32'd1);
            if (crd) begin
                check("crd_occ_le2", {31'd0, (occ <= 2)}, 32'd1);
                check("rd_addr", {20'd0, caddr_rd}, exp_rd);
                exp_rd++;
                occ++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {22'd0, out_idx}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", {12'd0, out_data}, {12'd0, e.data});
                    check("out_idx",  {22'd0, out_idx},  {22'd0, e.idx});
                    check("out_last", {31'd0, out_last}, {31'd0, e.last});
                end
                occ--;
            end
            stalled   = out_valid && !out_ready;
            prev_data = out_data;
            prev_idx  = out_idx;
            prev_last = out_last;
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},     {31'd0, busy},      32'd0);
        check({tag, "_done"},     {31'd0, done},      32'd0);
        check({tag, "_crd"},      {31'd0, crd},       32'd0);
        check({tag, "_caddr"},    {20'd0, caddr_rd},  32'd0);
        check({tag, "_csel"},     {29'd0, csel},      32'd0);
        check({tag, "_valid"},    {31'd0, out_valid}, 32'd0);
        check({tag, "_last"},     {31'd0, out_last},  32'd0);
        check({tag, "_data"},     {12'd0, out_data},  32'd0);
        check({tag, "_idx"},      {22'd0, out_idx},   32'd0);
        check({tag, "_sum"},      {2'd0, sum},        32'd0);
        check({tag, "_max_val"},  {12'd0, max_val},   32'd0);
        check({tag, "_max_idx"},  {22'd0, max_idx},   32'd0);
    endtask

    // check_timing: verify the cycle numbers for an always-ready stream.
    // repulse: pulse start again mid-run (must be ignored).
    // abort_at: assert reset at this cycle of the run (0 = never).
    task automatic run(input string tag, input bit check_timing, input bit repulse, input int abort_at);
        logic signed [63:0] s;
        logic signed [19:0] m;
        logic [9:0]         mi;
        int                 c;
        int                 d0;
        exp_t               e;

        // Reference results computed from the memory image
        s  = 0;
        m  = 0;
        mi = 0;
        for (int i = 0; i < 1024; i++) begin
            e.data = mem[i];
            e.idx  = 10'(i);
            e.last = (i == 1023);
            exp_q.push_back(e);
            s = s + 64'($signed(mem[i]));
            if (i == 0 || $signed(mem[i]) > m) begin
                m  = $signed(mem[i]);
                mi = 10'(i);
            end
        end

        @(posedge clk); #1;
        start = 1'b1;
        d0 = done_cnt;
        @(posedge clk); #1;          // start accepted at this edge (E0)
        start = 1'b0;

        c = 0;
        while (c < 20000) begin
            @(negedge clk);
            c++;
            if (check_timing && c == 1) begin
                check({tag, "_c1_crd"},   {31'd0, crd},       32'd1);
                check({tag, "_c1_addr"},  {20'd0, caddr_rd},  32'd0);
                check({tag, "_c1_valid"}, {31'd0, out_valid}, 32'd0);
                check({tag, "_c1_csel"},  {29'd0, csel},      32'd3);
                check({tag, "_c1_busy"},  {31'd0, busy},      32'd1);
            end
            if (check_timing && c == 2) begin
                check({tag, "_c2_valid"}, {31'd0, out_valid}, 32'd1);
                check({tag, "_c2_idx"},   {22'd0, out_idx},   32'd0);
            end
            if (repulse && c == 50) begin
                @(posedge clk); #1;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                c += 2;
            end
            if (abort_at != 0 && c == abort_at) begin
                @(posedge clk); #1;
                reset = 1'b1;
                exp_q.delete();
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                check_reset_values({tag, "_abort"});
                repeat (30) @(negedge clk);
                check({tag, "_abort_no_done"}, done_cnt, d0);
                return;
            end
            if (done) break;
        end

        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        if (check_timing) check({tag, "_done_cycle"}, c, 32'd1026);
        check({tag, "_q_empty"}, exp_q.size(), 32'd0);
        check({tag, "_sum"},     {2'd0, sum},      {2'd0, s[29:0]});
        check({tag, "_max_val"}, {12'd0, max_val}, {12'd0, m});
        check({tag, "_max_idx"}, {22'd0, max_idx}, {22'd0, mi});

        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done},  32'd0);
        check({tag, "_idle_busy"},  {31'd0, busy},  32'd0);
        check({tag, "_done_count"}, done_cnt, d0 + 1);
        repeat (5) @(negedge clk);
        check({tag, "_sum_hold"},     {2'd0, sum},      {2'd0, s[29:0]});
        check({tag, "_max_val_hold"}, {12'd0, max_val}, {12'd0, m});
        check({tag, "_max_idx_hold"}, {22'd0, max_idx}, {22'd0, mi});
        exp_q.delete();
    endtask

    task automatic set_ready_mode(input int mode);
        ready_mode = mode;
        repeat (12) @(posedge clk);   // let any stall in progress finish
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 20'(i);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_values("reset");

        // Ascending ramp, always ready: exact cycle timing and totals
        set_ready_mode(0);
        run("ramp", 1'b1, 1'b0, 0);
        check("ramp_sum_const", {2'd0, sum}, 32'd523776);

        // All -1: wrapped negative sum; ties keep index 0
        for (int i = 0; i < 1024; i++) mem[i] = 20'hFFFFF;
        set_ready_mode(1);
        run("neg", 1'b0, 1'b0, 0);
        check("neg_max_idx_const", {22'd0, max_idx}, 32'd0);

        // Random data with random backpressure and long stalls
        for (int i = 0; i < 1024; i++) mem[i] = 20'($urandom);
        run("rand", 1'b0, 1'b0, 0);

        // Single positive peak at word 500
        for (int i = 0; i < 1024; i++) mem[i] = 20'd0;
        mem[500] = 20'h7FFFF;
        set_ready_mode(0);
        run("peak", 1'b0, 1'b0, 0);

        // Reset mid-run, then a complete run
        for (int i = 0; i < 1024; i++) mem[i] = 20'(i);
        run("abort", 1'b0, 1'b0, 300);
        run("after_abort", 1'b1, 1'b0, 0);

        // start re-pulsed during RUN is ignored
        run("repulse", 1'b0, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
